// File: rtl/batch_tap_checker_if.sv
// Signal bundle for batch_tap_checker: clear, write port, packed tap checks, filter output and results.
// The checker takes the slave modport; whoever drives the checker takes master.
interface batch_tap_checker_if #(
   parameter int N     = 3,
   parameter int OSR   = 1,
   parameter int DEPTH = 32,
   parameter int TAPS  = 4,
   parameter int CNT_W = 16,
   parameter int OUT_W = 24
);
   localparam int SW  = N * OSR;
   localparam int DSD = (DEPTH + OSR - 1) / OSR;
   localparam int IW  = (DSD > 1) ? $clog2(DSD) : 1;
   localparam int TW  = (TAPS > 1) ? $clog2(TAPS) : 1;

   logic                    clear;
   logic                    in_valid;
   logic [1:0]              in_bank;
   logic [IW-1:0]           in_idx;
   logic [SW-1:0]           in_sample;
   logic [TAPS-1:0]         tap_valid;
   logic [2*TAPS-1:0]       tap_bank;
   logic [IW*TAPS-1:0]      tap_idx;
   logic [SW*TAPS-1:0]      tap_sample;
   logic [TAPS-1:0]         err_pulse;
   logic [TAPS-1:0]         miss_pulse;
   logic [CNT_W*TAPS-1:0]   err_count;
   logic                    first_valid;
   logic [TW-1:0]           first_tap;
   logic [IW-1:0]           first_idx;
   logic [SW-1:0]           first_exp;
   logic [SW-1:0]           first_got;
   logic                    out_valid;
   logic [OUT_W-1:0]        out_data;
   logic                    cont_pulse;
   logic [CNT_W-1:0]        cont_count;

   modport master (
      output clear, in_valid, in_bank, in_idx, in_sample,
      output tap_valid, tap_bank, tap_idx, tap_sample, out_valid, out_data,
      input  err_pulse, miss_pulse, err_count, first_valid, first_tap,
      input  first_idx, first_exp, first_got, cont_pulse, cont_count
   );

   modport slave (
      input  clear, in_valid, in_bank, in_idx, in_sample,
      input  tap_valid, tap_bank, tap_idx, tap_sample, out_valid, out_data,
      output err_pulse, miss_pulse, err_count, first_valid, first_tap,
      output first_idx, first_exp, first_got, cont_pulse, cont_count
   );
endinterface

// File: rtl/batch_tap_checker.sv
// Records words per bank/index and checks tap claims against them; flags 1 cycle after the check, never stalls.
// Output continuity check is built only when BATCH_TAP_CHECKER_CONT_EN is defined.
module batch_tap_checker #(
   parameter int N        = 3,
   parameter int OSR      = 1,
   parameter int DEPTH    = 32,
   parameter int TAPS     = 4,
   parameter int CNT_W    = 16,
   parameter int OUT_W    = 24,
   parameter int STEP_MAX = 2**20
) (
   input logic               clk,
   input logic               rst,
   batch_tap_checker_if.slave bus
);
   localparam int SW  = N * OSR;
   localparam int DSD = (DEPTH + OSR - 1) / OSR;
   localparam int IW  = (DSD > 1) ? $clog2(DSD) : 1;
   localparam int TW  = (TAPS > 1) ? $clog2(TAPS) : 1;

   logic [SW-1:0]    mem   [4][DSD];
   logic [DSD-1:0]   wbits [4];
   logic [CNT_W-1:0] cnt   [TAPS];

   logic [1:0]       t_bank [TAPS];
   logic [IW-1:0]    t_idx  [TAPS];
   logic [SW-1:0]    t_got  [TAPS];
   logic [SW-1:0]    t_exp  [TAPS];
   logic             t_wr   [TAPS];
   logic [TAPS-1:0]  t_err;
   logic [TAPS-1:0]  t_miss;
   logic             cap_hit;
   logic [TW-1:0]    cap_tap;
   logic             wr_ok;

   assign wr_ok = bus.in_valid && (int'(bus.in_idx) < DSD);

   // Lookups see the state before this edge's write, giving read-before-write.
   always_comb begin
      t_err   = '0;
      t_miss  = '0;
      cap_hit = 1'b0;
      cap_tap = '0;
      for (int t = 0; t < TAPS; t++) begin
         t_bank[t] = bus.tap_bank[2*t +: 2];
         t_idx[t]  = bus.tap_idx[IW*t +: IW];
         t_got[t]  = bus.tap_sample[SW*t +: SW];
         t_wr[t]   = 1'b0;
         t_exp[t]  = '0;
         if (int'(t_idx[t]) < DSD) begin
            t_wr[t]  = wbits[t_bank[t]][t_idx[t]];
            t_exp[t] = mem[t_bank[t]][t_idx[t]];
         end
         if (bus.tap_valid[t]) begin
            if (!t_wr[t])
               t_miss[t] = 1'b1;
            else if (t_exp[t] != t_got[t])
               t_err[t] = 1'b1;
         end
      end
      for (int t = TAPS - 1; t >= 0; t--) begin
         if (t_err[t]) begin
            cap_hit = 1'b1;
            cap_tap = TW'(t);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[bus.in_bank][bus.in_idx] <= bus.in_sample;
   end

   // Writing index 0 opens a new epoch for that bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++)
            wbits[k] <= '0;
      end else if (wr_ok) begin
         if (bus.in_idx == '0)
            wbits[bus.in_bank] <= DSD'(1);
         else
            wbits[bus.in_bank][bus.in_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.err_pulse   <= '0;
         bus.miss_pulse  <= '0;
         bus.first_valid <= 1'b0;
         bus.first_tap   <= '0;
         bus.first_idx   <= '0;
         bus.first_exp   <= '0;
         bus.first_got   <= '0;
         for (int t = 0; t < TAPS; t++)
            cnt[t] <= '0;
      end else begin
         bus.err_pulse  <= t_err;
         bus.miss_pulse <= t_miss;
         if (bus.clear) begin
            bus.first_valid <= 1'b0;
            bus.first_tap   <= '0;
            bus.first_idx   <= '0;
            bus.first_exp   <= '0;
            bus.first_got   <= '0;
            for (int t = 0; t < TAPS; t++)
               cnt[t] <= '0;
         end else begin
            for (int t = 0; t < TAPS; t++)
               if (t_err[t] && cnt[t] != '1)
                  cnt[t] <= cnt[t] + 1'b1;
            if (cap_hit && !bus.first_valid) begin
               bus.first_valid <= 1'b1;
               bus.first_tap   <= cap_tap;
               bus.first_idx   <= t_idx[cap_tap];
               bus.first_exp   <= t_exp[cap_tap];
               bus.first_got   <= t_got[cap_tap];
            end
         end
      end
   end

   always_comb begin
      bus.err_count = '0;
      for (int t = 0; t < TAPS; t++)
         bus.err_count[CNT_W*t +: CNT_W] = cnt[t];
   end

`ifdef BATCH_TAP_CHECKER_CONT_EN
   localparam logic [OUT_W:0] STEP_LIM = (OUT_W+1)'(STEP_MAX);

   logic [OUT_W-1:0]      prev;
   logic                  have_prev;
   logic signed [OUT_W:0] diff;
   logic [OUT_W:0]        mag;
   logic                  cont_hit;
   logic                  cpulse;
   logic [CNT_W-1:0]      ccnt;

   // One extra bit keeps the difference of two full-range words exact.
   always_comb begin
      diff     = $signed({bus.out_data[OUT_W-1], bus.out_data}) - $signed({prev[OUT_W-1], prev});
      mag      = diff[OUT_W] ? $unsigned(-diff) : $unsigned(diff);
      cont_hit = bus.out_valid && have_prev && (mag > STEP_LIM);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev      <= '0;
         have_prev <= 1'b0;
         cpulse    <= 1'b0;
         ccnt      <= '0;
      end else begin
         cpulse <= cont_hit;
         if (bus.out_valid) begin
            prev      <= bus.out_data;
            have_prev <= 1'b1;
         end
         if (bus.clear)
            ccnt <= '0;
         else if (cont_hit && ccnt != '1)
            ccnt <= ccnt + 1'b1;
      end
   end

   assign bus.cont_pulse = cpulse;
   assign bus.cont_count = ccnt;
`else
   assign bus.cont_pulse = 1'b0;
   assign bus.cont_count = '0;
   wire unused_cont = &{1'b0, bus.out_valid, bus.out_data, STEP_MAX[0], OUT_W[0]};
`endif
endmodule

// File: tb/tb_batch_tap_checker.sv
// Directed vector table, hand-written corner sequences and randomized traffic against a keyed reference model.
module tb_batch_tap_checker;
   localparam int N = 8, OSR = 1, DEPTH = 32, TAPS = 4, CNT_W = 6, OUT_W = 24, STEP_MAX = 2**20;
   localparam int SW = N * OSR, DSD = 32, IW = 5, TW = 2;
   localparam int CMAX = 2**CNT_W - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   batch_tap_checker_if #(.N(N), .OSR(OSR), .DEPTH(DEPTH), .TAPS(TAPS), .CNT_W(CNT_W), .OUT_W(OUT_W)) bus();
   batch_tap_checker #(.N(N), .OSR(OSR), .DEPTH(DEPTH), .TAPS(TAPS), .CNT_W(CNT_W),
                       .OUT_W(OUT_W), .STEP_MAX(STEP_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   // stimulus
   logic            wv, clr, ov;
   logic [1:0]      wb;
   logic [IW-1:0]   wi;
   logic [SW-1:0]   wd;
   logic [TAPS-1:0] tv;
   logic [1:0]      tbk [TAPS];
   logic [IW-1:0]   tix [TAPS];
   logic [SW-1:0]   tsm [TAPS];
   logic [OUT_W-1:0] od;

   // reference model: entries keyed by bank*64+idx, present only while written in the current epoch
   bit              wr_m  [int];
   logic [SW-1:0]   mem_m [int];
   int              cnt_m [TAPS];
   bit              fv_m;
   int              ft_m, fi_m, fe_m, fg_m;
   logic [TAPS-1:0] err_m, miss_m;
   bit              hp_m, cp_m;
   longint          prev_m;
   int              cc_m;

   typedef struct {
      logic wv; logic [1:0] wb; logic [4:0] wi; logic [7:0] wd; logic clr;
      logic [3:0] tv; logic [1:0] tbk; logic [4:0] tix; logic [31:0] ts;
      logic [3:0] e_err; logic [3:0] e_miss;
   } vec_t;
   vec_t vt [14];

   function automatic int key(input logic [1:0] b, input logic [IW-1:0] i);
      return int'(b) * 64 + int'(i);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      wv = 0; wb = 0; wi = 0; wd = 0; clr = 0; tv = 0; ov = 0;
      for (int t = 0; t < TAPS; t++) begin
         tbk[t] = 0; tix[t] = 0; tsm[t] = 0;
      end
   endtask

   task automatic cycle();
      logic [CNT_W*TAPS-1:0] cnt_v;
      longint cur, d;
      bus.clear = clr; bus.in_valid = wv; bus.in_bank = wb; bus.in_idx = wi; bus.in_sample = wd;
      bus.tap_valid = tv; bus.out_valid = ov; bus.out_data = od;
      for (int t = 0; t < TAPS; t++) begin
         bus.tap_bank[2*t +: 2]     = tbk[t];
         bus.tap_idx[IW*t +: IW]    = tix[t];
         bus.tap_sample[SW*t +: SW] = tsm[t];
      end
      err_m = '0; miss_m = '0; cp_m = 0;
      for (int t = 0; t < TAPS; t++)
         if (tv[t]) begin
            if (int'(tix[t]) >= DSD || !wr_m.exists(key(tbk[t], tix[t]))) miss_m[t] = 1'b1;
            else if (mem_m[key(tbk[t], tix[t])] !== tsm[t]) err_m[t] = 1'b1;
         end
`ifdef BATCH_TAP_CHECKER_CONT_EN
      if (ov) begin
         cur = longint'($signed(od));
         if (hp_m) begin
            d = cur - prev_m;
            if (d < 0) d = -d;
            if (d > STEP_MAX) cp_m = 1;
         end
         prev_m = cur; hp_m = 1;
      end
`endif
      if (rst) begin
         wr_m.delete();
         for (int t = 0; t < TAPS; t++) cnt_m[t] = 0;
         fv_m = 0; ft_m = 0; fi_m = 0; fe_m = 0; fg_m = 0;
         err_m = '0; miss_m = '0; hp_m = 0; cp_m = 0; cc_m = 0;
      end else begin
         if (clr) begin
            for (int t = 0; t < TAPS; t++) cnt_m[t] = 0;
            fv_m = 0; ft_m = 0; fi_m = 0; fe_m = 0; fg_m = 0; cc_m = 0;
         end else begin
            for (int t = 0; t < TAPS; t++)
               if (err_m[t] && cnt_m[t] < CMAX) cnt_m[t]++;
            if (!fv_m && err_m != 0) begin
               for (int t = TAPS - 1; t >= 0; t--) if (err_m[t]) ft_m = t;
               fv_m = 1;
               fi_m = int'(tix[ft_m]);
               fe_m = int'(mem_m[key(tbk[ft_m], tix[ft_m])]);
               fg_m = int'(tsm[ft_m]);
            end
            if (cp_m && cc_m < CMAX) cc_m++;
         end
         if (wv && int'(wi) < DSD) begin
            if (wi == 0) for (int i = 0; i < DSD; i++) wr_m.delete(int'(wb) * 64 + i);
            wr_m[key(wb, wi)] = 1;
            mem_m[key(wb, wi)] = wd;
         end
      end
      @(posedge clk);
      #1;
      for (int t = 0; t < TAPS; t++) cnt_v[CNT_W*t +: CNT_W] = CNT_W'(cnt_m[t]);
      check("err_pulse", 64'(bus.err_pulse), 64'(err_m));
      check("miss_pulse", 64'(bus.miss_pulse), 64'(miss_m));
      check("err_count", 64'(bus.err_count), 64'(cnt_v));
      check("first_capture", 64'({bus.first_valid, bus.first_tap, bus.first_idx, bus.first_exp, bus.first_got}),
            64'({fv_m, TW'(ft_m), IW'(fi_m), SW'(fe_m), SW'(fg_m)}));
      check("cont_pulse", 64'(bus.cont_pulse), 64'(cp_m));
      check("cont_count", 64'(bus.cont_count), 64'(cc_m));
   endtask

   task automatic apply_row(input int i);
      idle();
      wv = vt[i].wv; wb = vt[i].wb; wi = vt[i].wi; wd = vt[i].wd; clr = vt[i].clr; tv = vt[i].tv;
      for (int t = 0; t < TAPS; t++) begin
         tbk[t] = vt[i].tbk; tix[t] = vt[i].tix; tsm[t] = vt[i].ts[8*t +: 8];
      end
      cycle();
      check($sformatf("row%0d_err", i), 64'(bus.err_pulse), 64'(vt[i].e_err));
      check($sformatf("row%0d_miss", i), 64'(bus.miss_pulse), 64'(vt[i].e_miss));
   endtask

   task automatic cont_sample(input logic [OUT_W-1:0] v);
      idle(); ov = 1; od = v;
      cycle();
   endtask

   initial begin
      // wv wb wi wd clr tv tbk tix ts e_err e_miss (bank 1 preloaded with idx*3)
      vt[0]  = '{0, 0, 0, 0, 0, 4'b0001, 1, 5, {8'd0, 8'd0, 8'd0, 8'd15}, 4'b0000, 4'b0000};
      vt[1]  = '{0, 0, 0, 0, 0, 4'b0001, 1, 5, {8'd0, 8'd0, 8'd0, 8'd16}, 4'b0001, 4'b0000};
      vt[2]  = '{0, 0, 0, 0, 1, 4'b0000, 0, 0, 32'd0, 4'b0000, 4'b0000};
      vt[3]  = '{0, 0, 0, 0, 0, 4'b1010, 1, 5, {8'd17, 8'd0, 8'd16, 8'd0}, 4'b1010, 4'b0000};
      vt[4]  = '{0, 0, 0, 0, 0, 4'b1111, 1, 6, {8'd18, 8'd18, 8'd18, 8'd18}, 4'b0000, 4'b0000};
      vt[5]  = '{1, 1, 9, 99, 0, 4'b0001, 1, 9, {8'd0, 8'd0, 8'd0, 8'd27}, 4'b0000, 4'b0000};
      vt[6]  = '{0, 0, 0, 0, 0, 4'b0001, 1, 9, {8'd0, 8'd0, 8'd0, 8'd27}, 4'b0001, 4'b0000};
      vt[7]  = '{0, 0, 0, 0, 0, 4'b0100, 0, 3, 32'd0, 4'b0000, 4'b0100};
      vt[8]  = '{1, 1, 0, 0, 0, 4'b0001, 1, 0, 32'd0, 4'b0000, 4'b0000};
      vt[9]  = '{0, 0, 0, 0, 0, 4'b0001, 1, 7, {8'd0, 8'd0, 8'd0, 8'd21}, 4'b0000, 4'b0001};
      vt[10] = '{0, 0, 0, 0, 0, 4'b0001, 1, 9, {8'd0, 8'd0, 8'd0, 8'd99}, 4'b0000, 4'b0001};
      vt[11] = '{1, 1, 7, 21, 0, 4'b0001, 1, 7, {8'd0, 8'd0, 8'd0, 8'd21}, 4'b0000, 4'b0001};
      vt[12] = '{0, 0, 0, 0, 0, 4'b0001, 1, 7, {8'd0, 8'd0, 8'd0, 8'd21}, 4'b0000, 4'b0000};
      vt[13] = '{0, 0, 0, 0, 0, 4'b0001, 1, 5, {8'd0, 8'd0, 8'd0, 8'd15}, 4'b0000, 4'b0001};

      od = '0; prev_m = 0; hp_m = 0; cc_m = 0;
      idle(); rst = 1; cycle();
      check("reset_count", 64'(bus.err_count), 64'd0);
      rst = 0;

      for (int i = 0; i < DSD; i++) begin
         idle(); wv = 1; wb = 1; wi = IW'(i); wd = SW'(3 * i); cycle();
      end
      for (int i = 0; i < 2; i++) apply_row(i);
      check("first_tap_a", 64'(bus.first_tap), 64'd0);
      check("first_idx_a", 64'(bus.first_idx), 64'd5);
      check("first_exp_a", 64'(bus.first_exp), 64'd15);
      check("first_got_a", 64'(bus.first_got), 64'd16);
      check("count0_a", 64'(bus.err_count[0 +: CNT_W]), 64'd1);
      for (int i = 2; i < 4; i++) apply_row(i);
      check("first_tap_b", 64'(bus.first_tap), 64'd1);
      check("count1_b", 64'(bus.err_count[CNT_W +: CNT_W]), 64'd1);
      check("count3_b", 64'(bus.err_count[3*CNT_W +: CNT_W]), 64'd1);
      for (int i = 4; i < 14; i++) apply_row(i);

      // saturation then clear
      idle(); wv = 1; wb = 2; wi = 0; wd = 40; cycle();
      for (int i = 0; i < 2**CNT_W + 5; i++) begin
         idle(); tv[2] = 1; tbk[2] = 2; tix[2] = 0; tsm[2] = 41; cycle();
      end
      check("count2_sat", 64'(bus.err_count[2*CNT_W +: CNT_W]), 64'(CMAX));
      idle(); clr = 1; cycle();
      check("clear_count", 64'(bus.err_count), 64'd0);
      check("clear_first", 64'(bus.first_valid), 64'd0);
      idle(); tv[2] = 1; tbk[2] = 2; tix[2] = 0; tsm[2] = 40; cycle();
      check("clean_after_clear", 64'({bus.err_pulse, bus.miss_pulse}), 64'd0);

      // reset mid-batch with a pending failing check
      idle(); tv = 4'b1111; tbk[0] = 2; tix[0] = 0; tsm[0] = 7; wv = 1; wb = 3; wi = 4; wd = 5;
      rst = 1; cycle(); rst = 0;
      check("rst_outputs", 64'({bus.err_pulse, bus.miss_pulse, bus.err_count, bus.first_valid}), 64'd0);
      idle(); tv = 4'b1111;
      tbk[0] = 2; tix[0] = 0; tbk[1] = 1; tix[1] = 7; tbk[2] = 1; tix[2] = 5; tbk[3] = 3; tix[3] = 4;
      cycle();
      check("rst_all_miss", 64'(bus.miss_pulse), 64'hF);
      idle(); wv = 1; wb = 2; wi = 0; wd = 40; cycle();
      idle(); tv[0] = 1; tbk[0] = 2; tix[0] = 0; tsm[0] = 40; cycle();
      check("rewrite_clean", 64'({bus.err_pulse, bus.miss_pulse}), 64'd0);

      // continuity: first sample after reset only loads, then steps
      cont_sample(24'd0);
      cont_sample(24'd1000);
      cont_sample(24'(2**20 + 1001));
`ifdef BATCH_TAP_CHECKER_CONT_EN
      check("cont_third", 64'(bus.cont_pulse), 64'd1);
      check("cont_count_1", 64'(bus.cont_count), 64'd1);
`endif
      cont_sample(24'h800001);
      cont_sample(24'h7FFFFF);
`ifdef BATCH_TAP_CHECKER_CONT_EN
      check("cont_full_swing", 64'(bus.cont_pulse), 64'd1);
      check("cont_count_3", 64'(bus.cont_count), 64'd3);
`else
      check("cont_disabled", 64'({bus.cont_pulse, bus.cont_count}), 64'd0);
`endif

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         idle();
         rst = ($urandom_range(0, 299) == 0);
         clr = ($urandom_range(0, 59) == 0);
         wv = ($urandom_range(0, 9) < 6);
         wb = 2'($urandom); wi = IW'($urandom); wd = SW'($urandom);
         for (int t = 0; t < TAPS; t++) begin
            tv[t] = ($urandom_range(0, 2) != 0);
            tbk[t] = 2'($urandom); tix[t] = IW'($urandom);
            if (wr_m.exists(key(tbk[t], tix[t])) && $urandom_range(0, 1) == 1)
               tsm[t] = mem_m[key(tbk[t], tix[t])];
            else
               tsm[t] = SW'($urandom);
         end
         ov = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 1) == 1) od = od + 24'($urandom_range(0, 2**21)) - 24'(2**20);
         else od = 24'($urandom);
         cycle();
         rst = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
